// File: rtl/frame_bank_sequencer_if.sv
// Fill handshake between the frame bank sequencer (master) and the SPI
// fill path (slave). fill_bank is held stable while fill_req is high.
interface frame_bank_sequencer_if #(
  parameter int NUM_BANKS = 4
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic              fill_req;
  logic [BANK_W-1:0] fill_bank;
  logic              fill_done;

  modport master (output fill_req, output fill_bank, input fill_done);
  modport slave  (input fill_req, input fill_bank, output fill_done);
endinterface

// File: rtl/frame_bank_sequencer.sv
// Frame bank sequencer: manages a ring of NUM_BANKS frame banks between the
// fill path and VGA playback. Requests fills into free banks, selects the
// bank VGA reads from and advances playback every FRAME_REPEAT vsyncs.
// Optional build macro: BANK_SEQ_STATS_EN adds frames_played / underrun_cnt.
//
// state  | meaning
// IDLE   | waiting for an init rising edge, everything at reset values
// PRIME  | filling banks, VGA off until PRIME_DEPTH banks are valid
// PLAY   | VGA on, frame_tick drives the repeat counter and advances
// PAUSE  | VGA on, holding the current bank, fills continue
module frame_bank_sequencer #(
  parameter  int NUM_BANKS    = 4,
  parameter  int PRIME_DEPTH  = 2,
  parameter  int FRAME_REPEAT = 2,
  localparam int BANK_W       = $clog2(NUM_BANKS)
) (
  input  logic                   CLK_40,
  input  logic                   reset,
  input  logic                   init,
  input  logic                   pause_req,
  input  logic                   frame_tick,
  frame_bank_sequencer_if.master fill_if,
  output logic [BANK_W-1:0]      read_bank,
  output logic                   VGA_en,
  output logic [BANK_W:0]        occupancy,
  output logic                   underrun
`ifdef BANK_SEQ_STATS_EN
  ,
  output logic [15:0]            frames_played,
  output logic [7:0]             underrun_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_PLAY, ST_PAUSE} state_t;

  localparam logic [BANK_W:0]   OCC_FULL  = (BANK_W+1)'(NUM_BANKS);
  localparam logic [BANK_W:0]   OCC_PRIME = (BANK_W+1)'(PRIME_DEPTH);
  localparam logic [BANK_W:0]   OCC_TWO   = (BANK_W+1)'(2);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [7:0]        REP_LAST  = 8'(FRAME_REPEAT - 1);

  state_t            state_q, state_d;
  logic              init_q, init_d;
  logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BANK_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BANK_W:0]   occ_q, occ_d;
  logic              fill_req_q, fill_req_d;
  logic              underrun_q, underrun_d;
  logic [7:0]        rep_q, rep_d;
  logic              init_rise, fill_hit, adv_due, adv_ok;
`ifdef BANK_SEQ_STATS_EN
  logic [15:0]       frames_played_q, frames_played_d;
  logic [7:0]        underrun_cnt_q, underrun_cnt_d;
`endif

  function automatic logic [BANK_W-1:0] bank_next(input logic [BANK_W-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BANK_W'(1);
  endfunction

  // Next-state: restart on init edge, otherwise fill handshake, playback advance and state moves
  always_comb begin
    state_d    = state_q;
    init_d     = init;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    fill_req_d = fill_req_q;
    underrun_d = underrun_q;
    rep_d      = rep_q;
    init_rise  = init & ~init_q;
    fill_hit   = 1'b0;
    adv_due    = 1'b0;
    adv_ok     = 1'b0;
`ifdef BANK_SEQ_STATS_EN
    frames_played_d = frames_played_q;
    underrun_cnt_d  = underrun_cnt_q;
`endif
    if (init_rise) begin
      // Soft restart also covers the first start from IDLE; a fill_done
      // arriving now is dropped along with the outstanding request.
      state_d    = ST_PRIME;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      fill_req_d = 1'b0;
      underrun_d = 1'b0;
      rep_d      = '0;
`ifdef BANK_SEQ_STATS_EN
      frames_played_d = '0;
      underrun_cnt_d  = '0;
`endif
    end else if (state_q != ST_IDLE) begin
      fill_hit = fill_req_q & fill_if.fill_done;
      if (state_q == ST_PLAY && frame_tick) begin
        if (rep_q == REP_LAST) begin
          rep_d   = '0;
          adv_due = 1'b1;
        end else begin
          rep_d = rep_q + 8'd1;
        end
      end
      // The displayed bank is only released when a successor is ready.
      adv_ok = adv_due && (occ_q >= OCC_TWO);
      if (fill_hit) wr_ptr_d = bank_next(wr_ptr_q);
      if (adv_ok)   rd_ptr_d = bank_next(rd_ptr_q);
      if (adv_due && !adv_ok) underrun_d = 1'b1;
      occ_d = occ_q + (BANK_W+1)'(fill_hit) - (BANK_W+1)'(adv_ok);
      if (fill_req_q) fill_req_d = ~fill_if.fill_done;
      else            fill_req_d = (occ_q < OCC_FULL);
`ifdef BANK_SEQ_STATS_EN
      if (adv_ok && frames_played_q != 16'hFFFF)
        frames_played_d = frames_played_q + 16'd1;
      if (adv_due && !adv_ok && underrun_cnt_q != 8'hFF)
        underrun_cnt_d = underrun_cnt_q + 8'd1;
`endif
      case (state_q)
        ST_PRIME: if (occ_q >= OCC_PRIME) state_d = ST_PLAY;
        ST_PLAY:  if (pause_req)          state_d = ST_PAUSE;
        ST_PAUSE: if (!pause_req)         state_d = ST_PLAY;
        default:  ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      init_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      fill_req_q <= 1'b0;
      underrun_q <= 1'b0;
      rep_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      fill_req_q <= fill_req_d;
      underrun_q <= underrun_d;
      rep_q      <= rep_d;
    end
  end

`ifdef BANK_SEQ_STATS_EN
  // Playback statistics counters
  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      frames_played_q <= '0;
      underrun_cnt_q  <= '0;
    end else begin
      frames_played_q <= frames_played_d;
      underrun_cnt_q  <= underrun_cnt_d;
    end
  end

  assign frames_played = frames_played_q;
  assign underrun_cnt  = underrun_cnt_q;
`endif

  assign fill_if.fill_req  = fill_req_q;
  assign fill_if.fill_bank = wr_ptr_q;
  assign read_bank         = rd_ptr_q;
  assign VGA_en            = (state_q == ST_PLAY) || (state_q == ST_PAUSE);
  assign occupancy         = occ_q;
  assign underrun          = underrun_q;

endmodule

// File: tb/tb_frame_bank_sequencer.sv
// Self-checking bench for frame_bank_sequencer. A reference model holds the
// valid banks as a queue (front = displayed bank) and is compared with the
// DUT outputs on every falling edge.
module tb_frame_bank_sequencer;
  localparam int NB = 4;
  localparam int PD = 2;
  localparam int FR = 2;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          init = 1'b0;
  logic          pause_req = 1'b0;
  logic          frame_tick = 1'b0;
  logic [BW-1:0] read_bank;
  logic          vga_en;
  logic [BW:0]   occupancy;
  logic          underrun;
`ifdef BANK_SEQ_STATS_EN
  logic [15:0]   frames_played;
  logic [7:0]    underrun_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  frame_bank_sequencer_if #(.NUM_BANKS(NB)) fill_if ();

  frame_bank_sequencer #(.NUM_BANKS(NB), .PRIME_DEPTH(PD), .FRAME_REPEAT(FR)) dut (
    .CLK_40     (clk),
    .reset      (rst_n),
    .init       (init),
    .pause_req  (pause_req),
    .frame_tick (frame_tick),
    .fill_if    (fill_if),
    .read_bank  (read_bank),
    .VGA_en     (vga_en),
    .occupancy  (occupancy),
    .underrun   (underrun)
`ifdef BANK_SEQ_STATS_EN
    ,
    .frames_played (frames_played),
    .underrun_cnt  (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_phase;      // 0 idle, 1 prime, 2 play, 3 pause
  int m_banks[$];   // valid banks, oldest (displayed) first
  int m_next_fill;
  int m_rd;
  int m_rep;
  int m_played;
  int m_urcnt;
  bit m_req;
  bit m_under;
  bit m_init_prev;
  bit m_rise, m_filled, m_due;
  int m_sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_banks.delete(); m_next_fill = 0; m_rd = 0; m_rep = 0;
      m_played = 0; m_urcnt = 0; m_req = 0; m_under = 0; m_init_prev = 0;
    end else begin
      m_rise = init && !m_init_prev;
      m_init_prev = init;
      if (m_rise) begin
        m_phase = 1; m_banks.delete(); m_next_fill = 0; m_rd = 0; m_rep = 0;
        m_played = 0; m_urcnt = 0; m_req = 0; m_under = 0;
      end else if (m_phase != 0) begin
        m_sz = m_banks.size();
        m_filled = m_req && fill_if.fill_done;
        m_due = 0;
        if (m_phase == 2 && frame_tick) begin
          m_rep++;
          if (m_rep == FR) begin m_rep = 0; m_due = 1; end
        end
        if (m_due && m_sz >= 2) begin
          void'(m_banks.pop_front());
          m_rd = m_banks[0];
          if (m_played < 65535) m_played++;
        end else if (m_due) begin
          m_under = 1;
          if (m_urcnt < 255) m_urcnt++;
        end
        if (m_filled) begin
          m_banks.push_back(m_next_fill);
          m_next_fill = (m_next_fill + 1) % NB;
          m_req = 0;
        end else if (!m_req) begin
          m_req = (m_sz < NB);
        end
        case (m_phase)
          1: if (m_sz >= PD) m_phase = 2;
          2: if (pause_req) m_phase = 3;
          3: if (!pause_req) m_phase = 2;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [9:0] exp_vec();
    return {m_req, BW'(m_next_fill), BW'(m_rd), (m_phase >= 2), 3'(m_banks.size()), m_under};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {fill_if.fill_req, fill_if.fill_bank, read_bank, vga_en, occupancy, underrun};
  endfunction

  // Fill-path responder: answers a pending request after a random delay.
  int resp_wait = -1;
  task automatic respond(input bit enable, output bit fd);
    fd = 1'b0;
    if (!enable || !fill_if.fill_req) begin
      resp_wait = -1;
      return;
    end
    if (resp_wait < 0) resp_wait = $urandom_range(0, 8);
    if (resp_wait == 0) begin
      fd = 1'b1;
      resp_wait = -1;
    end else begin
      resp_wait--;
    end
  endtask

  task automatic quiesce();
    @(negedge clk);
    frame_tick = 1'b0;
    fill_if.fill_done = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    fill_if.fill_done = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_vec() !== 10'd0) begin
      n_errors++; $display("FAIL reset_outputs got %b expected %b", dut_vec(), 10'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_errors++; $display("FAIL idle_outputs got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_prime();
    int fills = 0;
    bit fd;
    logic [BW-1:0] seen[$];
    @(negedge clk);
    init = 1'b1;
    for (int cyc = 0; cyc < 200 && fills < 2; cyc++) begin
      @(negedge clk);
      init = 1'b0;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL prime_cycle got %b expected %b", dut_vec(), exp_vec());
      end
      if (fill_if.fill_req && seen.size() == fills) seen.push_back(fill_if.fill_bank);
      respond(1'b1, fd);
      fill_if.fill_done = fd;
      if (fd) fills++;
    end
    n_checks++;
    if (fills != 2) begin
      n_errors++; $display("FAIL prime_timeout got %0d fills expected 2", fills);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      respond(1'b0, fd);
      fill_if.fill_done = fd;
    end
    n_checks++;
    if (seen.size() != 2 || seen[0] !== 2'd0 || seen[1] !== 2'd1) begin
      n_errors++; $display("FAIL prime_fill_banks got %p expected 0,1", seen);
    end
    n_checks++;
    if (occupancy !== 3'd2 || vga_en !== 1'b1 || read_bank !== 2'd0) begin
      n_errors++;
      $display("FAIL prime_to_play got occ=%0d vga=%b rb=%0d expected occ=2 vga=1 rb=0",
               occupancy, vga_en, read_bank);
    end
  endtask

  task automatic test_play();
    int adv = 0;
    int exp_rb = 0;
    int gap;
    bit fd;
    logic [BW-1:0] last_rb;
    last_rb = read_bank;
    gap = $urandom_range(8, 20);
    for (int cyc = 0; cyc < 3000 && adv < 8; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL play_cycle got %b expected %b", dut_vec(), exp_vec());
      end
      if (read_bank !== last_rb) begin
        adv++;
        exp_rb = (exp_rb + 1) % NB;
        n_checks++;
        if (read_bank !== BW'(exp_rb)) begin
          n_errors++; $display("FAIL play_step got %0d expected %0d", read_bank, exp_rb);
        end
        last_rb = read_bank;
      end
      respond(1'b1, fd);
      fill_if.fill_done = fd;
      if (gap == 0) begin frame_tick = 1'b1; gap = $urandom_range(8, 20); end
      else begin frame_tick = 1'b0; gap--; end
    end
    frame_tick = 1'b0;
    n_checks++;
    if (adv != 8) begin
      n_errors++; $display("FAIL play_timeout got %0d advances expected 8", adv);
    end
    n_checks++;
    if (underrun !== 1'b0) begin
      n_errors++; $display("FAIL play_underrun got %b expected 0", underrun);
    end
  endtask

  task automatic test_underrun();
    int r0, s0;
    bit fd;
    quiesce();
    r0 = m_rd;
    s0 = m_banks.size();
    for (int cyc = 0; cyc < 72; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL underrun_cycle got %b expected %b", dut_vec(), exp_vec());
      end
      respond(1'b0, fd);
      fill_if.fill_done = fd;
      frame_tick = (cyc < 64 && cyc % 4 == 0);
    end
    frame_tick = 1'b0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== 3'd1 || underrun !== 1'b1 || read_bank !== BW'((r0 + s0 - 1) % NB)) begin
      n_errors++;
      $display("FAIL underrun_drain got occ=%0d ur=%b rb=%0d expected occ=1 ur=1 rb=%0d",
               occupancy, underrun, read_bank, (r0 + s0 - 1) % NB);
    end
  endtask

  task automatic test_full();
    bit fd;
    quiesce();
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL full_cycle got %b expected %b", dut_vec(), exp_vec());
      end
      respond(1'b1, fd);
      fill_if.fill_done = fd;
    end
    quiesce();
    n_checks++;
    if (occupancy !== 3'd4 || fill_if.fill_req !== 1'b0) begin
      n_errors++; $display("FAIL full_saturate got occ=%0d req=%b expected occ=4 req=0",
                           occupancy, fill_if.fill_req);
    end
    fill_if.fill_done = 1'b1;
    @(negedge clk);
    fill_if.fill_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== 3'd4 || fill_if.fill_req !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_errors++; $display("FAIL full_stray_done got occ=%0d req=%b expected occ=4 req=0",
                           occupancy, fill_if.fill_req);
    end
  endtask

  task automatic test_simul_pause();
    int stage = 0;
    int pre_rd = 0, pre_wr = 0;
    bit fd;
    quiesce();
    for (int cyc = 0; cyc < 60 && stage < 2; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL simul_cycle got %b expected %b", dut_vec(), exp_vec());
      end
      frame_tick = 1'b0;
      fill_if.fill_done = 1'b0;
      if (stage == 0) begin
        if (m_banks.size() == 3) stage = 1;
        else frame_tick = (cyc % 2 == 0);
      end
      if (stage == 1) begin
        if (m_rep == FR - 1 && m_req) begin
          pre_rd = m_rd; pre_wr = m_next_fill;
          frame_tick = 1'b1; fill_if.fill_done = 1'b1;
          stage = 2;
        end else if (m_rep != FR - 1) begin
          frame_tick = (cyc % 2 == 0);
        end
      end
    end
    @(negedge clk);
    frame_tick = 1'b0;
    fill_if.fill_done = 1'b0;
    n_checks++;
    if (stage != 2 || occupancy !== 3'd3 || read_bank !== BW'((pre_rd + 1) % NB) ||
        fill_if.fill_bank !== BW'((pre_wr + 1) % NB)) begin
      n_errors++;
      $display("FAIL simul_fill_adv got occ=%0d rb=%0d wb=%0d expected occ=3 rb=%0d wb=%0d",
               occupancy, read_bank, fill_if.fill_bank, (pre_rd + 1) % NB, (pre_wr + 1) % NB);
    end
    pause_req = 1'b1;
    for (int cyc = 0; cyc < 26; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL pause_cycle got %b expected %b", dut_vec(), exp_vec());
      end
      respond(1'b1, fd);
      fill_if.fill_done = fd;
      frame_tick = (cyc % 6 == 5);
    end
    frame_tick = 1'b0;
    @(negedge clk);
    n_checks++;
    if (read_bank !== BW'((pre_rd + 1) % NB) || vga_en !== 1'b1) begin
      n_errors++; $display("FAIL pause_hold got rb=%0d vga=%b expected rb=%0d vga=1",
                           read_bank, vga_en, (pre_rd + 1) % NB);
    end
    pause_req = 1'b0;
  endtask

  task automatic test_random();
    bit fd;
    bit resp_en = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL random_cycle got %b expected %b", dut_vec(), exp_vec());
      end
      if ($urandom_range(0, 29) == 0) resp_en = !resp_en;
      if ($urandom_range(0, 19) == 0) pause_req = !pause_req;
      respond(resp_en, fd);
      fill_if.fill_done = fd;
      frame_tick = ($urandom_range(0, 5) == 0);
    end
    frame_tick = 1'b0;
    pause_req = 1'b0;
`ifdef BANK_SEQ_STATS_EN
    @(negedge clk);
    n_checks++;
    if (frames_played !== 16'(m_played) || underrun_cnt !== 8'(m_urcnt)) begin
      n_errors++; $display("FAIL random_stats got %0d/%0d expected %0d/%0d",
                           frames_played, underrun_cnt, m_played, m_urcnt);
    end
`endif
  endtask

  task automatic test_restart();
    bit fd;
    bit found = 1'b0;
    int gap;
    quiesce();
    for (int cyc = 0; cyc < 400 && !found; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL restart_seek got %b expected %b", dut_vec(), exp_vec());
      end
      if (m_phase == 2 && m_req) begin
        init = 1'b1;
        fill_if.fill_done = 1'b1;
        frame_tick = 1'b0;
        found = 1'b1;
      end else begin
        respond(1'b1, fd);
        fill_if.fill_done = fd;
        frame_tick = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    init = 1'b0;
    fill_if.fill_done = 1'b0;
    frame_tick = 1'b0;
    n_checks++;
    if (!found || dut_vec() !== 10'd0) begin
      n_errors++; $display("FAIL restart_clear got %b expected %b", dut_vec(), 10'd0);
    end
`ifdef BANK_SEQ_STATS_EN
    n_checks++;
    if (frames_played !== 16'd0 || underrun_cnt !== 8'd0) begin
      n_errors++; $display("FAIL restart_stats got %0d/%0d expected 0/0", frames_played, underrun_cnt);
    end
`endif
    gap = $urandom_range(8, 20);
    for (int cyc = 0; cyc < 1500 && m_played < 3; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL restart_cycle got %b expected %b", dut_vec(), exp_vec());
      end
      respond(1'b1, fd);
      fill_if.fill_done = fd;
      if (gap == 0) begin frame_tick = 1'b1; gap = $urandom_range(8, 20); end
      else begin frame_tick = 1'b0; gap--; end
    end
    frame_tick = 1'b0;
    n_checks++;
    if (read_bank !== 2'd3 || underrun !== 1'b0) begin
      n_errors++; $display("FAIL restart_replay got rb=%0d ur=%b expected rb=3 ur=0", read_bank, underrun);
    end
`ifdef BANK_SEQ_STATS_EN
    n_checks++;
    if (frames_played !== 16'd3) begin
      n_errors++; $display("FAIL restart_frames_played got %0d expected 3", frames_played);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_prime();
    test_play();
    test_underrun();
    test_full();
    test_simul_pause();
    test_random();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_bank_sequencer.md
Name: frame_bank_sequencer

Overview:
Parametrised successor to the two-bank read_bank1/read_bank2 control. It manages a ring of NUM_BANKS video frame banks between the SPI fill path (DATA_FSM) and VGA playback (video_top). It issues fill requests to free banks, selects the bank VGA reads from, and advances playback every FRAME_REPEAT vsyncs. It also handles priming, pause and underrun.

Parameters:
NUM_BANKS, 4, number of frame banks in the ring (2..16)
BANK_W, $clog2(NUM_BANKS), width of bank index ports (derived, not overridden)
PRIME_DEPTH, 2, banks that must be full before playback starts (1..NUM_BANKS)
FRAME_REPEAT, 2, VGA frames shown per video frame (1..255)

Ports:
CLK_40  input  1  system clock, 40 MHz
reset  input  1  asynchronous, active-low reset (0 = in reset)
init  input  1  start request, level; rising edge detected internally
pause_req  input  1  level; high holds playback on current bank
frame_tick  input  1  one-cycle pulse per VGA frame (vsync start)
fill_done  input  1  one-cycle pulse from DATA_FSM: requested bank fully written
fill_req  output  1  level; a bank fill is requested and outstanding
fill_bank  output  BANK_W  bank index to be written; stable while fill_req high
read_bank  output  BANK_W  bank index VGA reads from
VGA_en  output  1  VGA sync/output enable
occupancy  output  BANK_W+1  number of valid banks, including the displayed bank
underrun  output  1  sticky; set when an advance is due and no next bank is ready

Behaviour:
- Reset (async assert, sync release): state=IDLE, wr_ptr=0, rd_ptr=0, occupancy=0, fill_req=0, fill_bank=0, read_bank=0, VGA_en=0, underrun=0, repeat counter=0.
- States:
  - IDLE: all outputs at reset values. Rising edge of init -> PRIME.
  - PRIME: fill logic active; VGA_en=0. When occupancy reaches PRIME_DEPTH -> PLAY on the next cycle. read_bank=rd_ptr=0.
  - PLAY: VGA_en=1. Each frame_tick increments repeat counter. When the count reaches FRAME_REPEAT, the counter clears and an advance is due.
  - PAUSE: entered from PLAY when pause_req=1; VGA_en stays 1. frame_tick is ignored and the repeat counter is held. Fill logic stays active. pause_req=0 -> PLAY.
- init rising edge in PRIME/PLAY/PAUSE: soft restart. All pointers, occupancy and underrun return to reset values; state -> PRIME. An outstanding fill is dropped; a fill_done in the same cycle is ignored.
- Fill logic (PRIME/PLAY/PAUSE):
  - fill_req rises the cycle after (occupancy < NUM_BANKS and no fill outstanding).
  - fill_bank = wr_ptr.
  - On fill_done while outstanding: wr_ptr wraps mod NUM_BANKS, occupancy+1, fill_req drops the same edge. The next request can assert no earlier than the following cycle.
  - fill_done with no fill outstanding is ignored.
- Advance: if occupancy >= 2, rd_ptr wraps +1 mod NUM_BANKS, read_bank updates on the same edge, and occupancy-1 (releases the displayed bank). If occupancy < 2, rd_ptr is held, underrun is set, and the repeat counter still clears.
- Simultaneous fill_done and successful advance: occupancy unchanged, both pointers move.
- Full: occupancy==NUM_BANKS -> no fill_req. wr_ptr==rd_ptr is legal only when full or empty.
- underrun clears only on reset or soft restart.
- A pause_req arriving on the same cycle as an advance-due frame_tick: the advance completes first, then -> PAUSE.

Optional Feature:
Macro BANK_SEQ_STATS_EN.
- Defined: adds output frames_played [15:0], incremented on each successful advance and saturating at 16'hFFFF. Adds output underrun_cnt [7:0], incremented on each failed advance and saturating at 8'hFF. Both clear on reset and soft restart.
- Not defined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then init edge with NUM_BANKS=4, PRIME_DEPTH=2 -> fill_req with fill_bank=0, then 1. After the 2nd fill_done: occupancy=2, state PLAY, VGA_en=1, read_bank=0.
- PLAY with FRAME_REPEAT=2 and fills answered within 10 cycles -> read_bank steps 0,1,2,3,0 every 2 frame_ticks; underrun stays 0.
- Stop answering fill_done; issue frame_ticks -> occupancy drains to 1, next advance sets underrun=1, and read_bank is held.
- Answer fills with no frame_ticks -> occupancy saturates at 4, fill_req stays 0; a stray fill_done leaves occupancy at 4.
- fill_done on the same cycle as an advance-due frame_tick at occupancy=3 -> occupancy stays 3, rd_ptr+1, wr_ptr+1. Then pause_req=1 with 4 frame_ticks -> read_bank unchanged.
- Second init edge mid-PLAY with fill outstanding -> pointers=0, occupancy=0, underrun=0, state PRIME. With BANK_SEQ_STATS_EN: frames_played=0 after restart, and it counts 3 after three successful advances.
